// File: rtl/printhead_capture_controller.sv
// Printhead snoop: samples an asynchronous printhead clock/data/latch bus, feeds an external SIPO,
// and emits the captured dots as a valid/ready word stream with per-line completion and error flags.
module printhead_capture_controller #(
    parameter int WORD_WIDTH    = 8,
    parameter int MAX_LINE_BITS = 832,
    localparam int LB_W         = $clog2(MAX_LINE_BITS + 1),
    localparam int WB_W         = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  ph_clk,
    input  logic                  ph_data,
    input  logic                  ph_latch,
    output logic                  sr_write_data,
    output logic                  sr_write_enable,
    input  logic [WORD_WIDTH-1:0] sr_read_data,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic [WB_W-1:0]       word_bits,
    output logic                  word_last,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  line_done,
    output logic [LB_W-1:0]       line_bits,
    output logic                  overrun,
    output logic                  line_overflow,
    input  logic                  status_clear
);

    localparam logic [WB_W-1:0] WORD_FULL = WB_W'(WORD_WIDTH);
    localparam logic [LB_W-1:0] LINE_MAX  = LB_W'(MAX_LINE_BITS);

    typedef enum logic [1:0] {DISABLED, CAPTURE, LOAD_WORD, FLUSH} state_t;

    state_t          state;
    logic            ph_clk_s1, ph_clk_s2, ph_clk_s3;
    logic            ph_data_s1, ph_data_s2;
    logic            ph_latch_s1, ph_latch_s2, ph_latch_s3;
    logic [1:0]      prime_cnt;
    logic            clk_rise, latch_rise;
    logic [WB_W-1:0] bits_in_word;
    logic [LB_W-1:0] line_count;
    logic            flush_pending;
    logic            load_now;
    logic [WB_W-1:0] load_bits;
    logic            load_last;

    // Edges seen while the synchroniser is still filling after reset are stale, so they are masked.
    always_ff @(posedge clk) begin
        if (reset) begin
            {ph_clk_s1, ph_clk_s2, ph_clk_s3}       <= '0;
            {ph_data_s1, ph_data_s2}                <= '0;
            {ph_latch_s1, ph_latch_s2, ph_latch_s3} <= '0;
            prime_cnt                               <= '0;
        end else begin
            {ph_clk_s3, ph_clk_s2, ph_clk_s1}       <= {ph_clk_s2, ph_clk_s1, ph_clk};
            {ph_data_s2, ph_data_s1}                <= {ph_data_s1, ph_data};
            {ph_latch_s3, ph_latch_s2, ph_latch_s1} <= {ph_latch_s2, ph_latch_s1, ph_latch};
            if (prime_cnt != 2'd3)
                prime_cnt <= prime_cnt + 2'd1;
        end
    end

    assign clk_rise   = ph_clk_s2 & ~ph_clk_s3 & (prime_cnt == 2'd3);
    assign latch_rise = ph_latch_s2 & ~ph_latch_s3 & (prime_cnt == 2'd3);

    always_comb begin
        load_now  = 1'b0;
        load_bits = WORD_FULL;
        load_last = 1'b0;
        if (enable) begin
            case (state)
                LOAD_WORD: load_now = 1'b1;
                FLUSH: begin
                    load_now  = (bits_in_word != '0);
                    load_bits = bits_in_word;
                    load_last = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Error-flag sets come after status_clear so a same-cycle set wins; SIPO reads happen at least
    // one cycle after the last sr_write_enable so the newest bit is already shifted in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= DISABLED;
            sr_write_enable <= 1'b0;
            sr_write_data   <= 1'b0;
            word_data       <= '0;
            word_bits       <= '0;
            word_last       <= 1'b0;
            word_valid      <= 1'b0;
            line_done       <= 1'b0;
            line_bits       <= '0;
            overrun         <= 1'b0;
            line_overflow   <= 1'b0;
            bits_in_word    <= '0;
            line_count      <= '0;
            flush_pending   <= 1'b0;
        end else begin
            sr_write_enable <= 1'b0;
            line_done       <= 1'b0;
            if (status_clear) begin
                overrun       <= 1'b0;
                line_overflow <= 1'b0;
            end

            if (load_now) begin
                if (!word_valid || word_ready) begin
                    word_valid <= 1'b1;
                    word_data  <= sr_read_data;
                    word_bits  <= load_bits;
                    word_last  <= load_last;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_ready) begin
                word_valid <= 1'b0;
            end

            if (!enable) begin
                state         <= DISABLED;
                bits_in_word  <= '0;
                line_count    <= '0;
                flush_pending <= 1'b0;
            end else begin
                case (state)
                    DISABLED: state <= CAPTURE;
                    CAPTURE: begin
                        if (bits_in_word == WORD_FULL) begin
                            state <= LOAD_WORD;
                            if (latch_rise)
                                flush_pending <= 1'b1;
                        end else if (clk_rise) begin
                            sr_write_enable <= 1'b1;
                            sr_write_data   <= ph_data_s2;
                            bits_in_word    <= bits_in_word + 1'b1;
                            if (line_count == LINE_MAX)
                                line_overflow <= 1'b1;
                            else
                                line_count <= line_count + 1'b1;
                            if (latch_rise)
                                flush_pending <= 1'b1;
                        end else if (latch_rise || flush_pending) begin
                            state <= FLUSH;
                        end
                    end
                    LOAD_WORD: begin
                        bits_in_word  <= '0;
                        flush_pending <= 1'b0;
                        state         <= (flush_pending || latch_rise) ? FLUSH : CAPTURE;
                    end
                    FLUSH: begin
                        line_done     <= 1'b1;
                        line_bits     <= line_count;
                        flush_pending <= 1'b0;
                        state         <= CAPTURE;
                        // A dot clocked right after the latch is the first bit of the next line.
                        if (clk_rise) begin
                            sr_write_enable <= 1'b1;
                            sr_write_data   <= ph_data_s2;
                            bits_in_word    <= WB_W'(1);
                            line_count      <= LB_W'(1);
                        end else begin
                            bits_in_word <= '0;
                            line_count   <= '0;
                        end
                    end
                    default: state <= DISABLED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_printhead_capture_controller.sv
// Self-checking bench: table-driven lines, randomized lines against a line-level word model,
// and hand-written sequences for overrun, overflow, enable and reset corner cases.
module tb_printhead_capture_controller;

    localparam int WW       = 8;
    localparam int MAX_LINE = 832;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] b;
        logic       l;
    } word_t;

    typedef struct {
        int          n;
        logic [15:0] pattern;
        bit          coincide;
        int          exp_words;
        logic [7:0]  exp_first_data;
        int          exp_first_bits;
        int          exp_last_bits;
        int          exp_last_flag;
        int          exp_line;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       ph_clk = 1'b0, ph_data = 1'b0, ph_latch = 1'b0;
    logic       sr_write_data, sr_write_enable;
    logic [7:0] sr_read_data;
    logic [7:0] word_data;
    logic [3:0] word_bits;
    logic       word_last, word_valid;
    logic       word_ready = 1'b1;
    logic       line_done;
    logic [9:0] line_bits;
    logic       overrun, line_overflow;
    logic       status_clear = 1'b0;

    int    checks = 0;
    int    errors = 0;
    int    we_count = 0;
    int    double_we = 0;
    int    sent_bits = 0;
    bit    prev_we = 1'b0;
    bit    prev_hold = 1'b0;
    word_t held;
    word_t got_q[$];
    int    line_q[$];
    bit    stim_q[$];
    vec_t  vecs[7];

    printhead_capture_controller #(.WORD_WIDTH(WW), .MAX_LINE_BITS(MAX_LINE)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .ph_clk(ph_clk), .ph_data(ph_data), .ph_latch(ph_latch),
        .sr_write_data(sr_write_data), .sr_write_enable(sr_write_enable),
        .sr_read_data(sr_read_data),
        .word_data(word_data), .word_bits(word_bits), .word_last(word_last),
        .word_valid(word_valid), .word_ready(word_ready),
        .line_done(line_done), .line_bits(line_bits),
        .overrun(overrun), .line_overflow(line_overflow), .status_clear(status_clear)
    );

    always #5 clk = ~clk;

    // External SIPO: bit 0 holds the newest bit.
    always @(posedge clk) begin
        if (reset) sr_read_data <= '0;
        else if (sr_write_enable) sr_read_data <= {sr_read_data[6:0], sr_write_data};
    end

    // Stream monitor: records accepted words and line completions, and checks held words stay stable.
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
            prev_we   = 1'b0;
        end else begin
            if (sr_write_enable) begin
                we_count++;
                if (prev_we) double_we++;
            end
            prev_we = sr_write_enable;
            if (prev_hold) begin
                checks++;
                if (!word_valid || word_data != held.d || word_bits != held.b || word_last != held.l) begin
                    errors++;
                    $display("[TB] FAIL hold_stable: got v=%0b d=%h b=%0d l=%0b, required v=1 d=%h b=%0d l=%0b",
                             word_valid, word_data, word_bits, word_last, held.d, held.b, held.l);
                end
            end
            if (word_valid && word_ready) got_q.push_back({word_data, word_bits, word_last});
            if (line_done) line_q.push_back(int'(line_bits));
            prev_hold = word_valid && !word_ready;
            held      = {word_data, word_bits, word_last};
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b, input bit with_latch);
        ph_data = b;
        tick(1);
        ph_clk = 1'b1;
        if (with_latch) ph_latch = 1'b1;
        tick(3);
        ph_clk   = 1'b0;
        ph_latch = 1'b0;
        tick(3 + $urandom_range(0, 2));
        sent_bits++;
    endtask

    task automatic send_latch();
        ph_latch = 1'b1;
        tick(3);
        ph_latch = 1'b0;
        tick(3);
    endtask

    // Sends stim_q as one line; the latch either coincides with the last dot clock or follows it.
    task automatic applyStimulus(input bit coincide);
        for (int i = 0; i < stim_q.size(); i++)
            send_bit(stim_q[i], coincide && (i == stim_q.size() - 1));
        if (!coincide) send_latch();
        tick(10);
    endtask

    // Line-level model: every 8 dots form a full word (first dot at the MSB), a remainder forms a
    // final partial word whose low bits hold the remaining dots, and the line length saturates.
    task automatic verify_line(input string tag);
        int n, nfull, r, exp_words, nb, exp_line;
        logic [7:0] d, mask;
        n         = stim_q.size();
        nfull     = n / WW;
        r         = n % WW;
        exp_words = nfull + ((r > 0) ? 1 : 0);
        exp_line  = (n > MAX_LINE) ? MAX_LINE : n;
        checkOutput({tag, " word_count"}, got_q.size(), exp_words);
        for (int w = 0; w < exp_words && w < got_q.size(); w++) begin
            nb = (w < nfull) ? WW : r;
            d  = '0;
            for (int k = 0; k < nb; k++) d = {d[6:0], stim_q[WW * w + k]};
            mask = 8'((1 << nb) - 1);
            checkOutput({tag, " word_data"}, int'(got_q[w].d & mask), int'(d & mask));
            checkOutput({tag, " word_bits"}, int'(got_q[w].b), nb);
            checkOutput({tag, " word_last"}, int'(got_q[w].l), (w >= nfull) ? 1 : 0);
        end
        checkOutput({tag, " line_done_count"}, line_q.size(), 1);
        if (line_q.size() > 0) checkOutput({tag, " line_bits"}, line_q[0], exp_line);
        checkOutput({tag, " line_overflow"}, int'(line_overflow), (n > MAX_LINE) ? 1 : 0);
        checkOutput({tag, " overrun"}, int'(overrun), 0);
        got_q.delete();
        line_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk);
        checkOutput({tag, " sr_write_enable"}, int'(sr_write_enable), 0);
        checkOutput({tag, " sr_write_data"}, int'(sr_write_data), 0);
        checkOutput({tag, " word_valid"}, int'(word_valid), 0);
        checkOutput({tag, " word_data"}, int'(word_data), 0);
        checkOutput({tag, " word_bits"}, int'(word_bits), 0);
        checkOutput({tag, " word_last"}, int'(word_last), 0);
        checkOutput({tag, " line_done"}, int'(line_done), 0);
        checkOutput({tag, " line_bits"}, int'(line_bits), 0);
        checkOutput({tag, " overrun"}, int'(overrun), 0);
        checkOutput({tag, " line_overflow"}, int'(line_overflow), 0);
    endtask

    task automatic pulse_status_clear();
        status_clear = 1'b1;
        tick(1);
        status_clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int idx;
        vecs[0] = '{8,  16'h00B2, 1'b0, 1, 8'hB2, 8, 8, 0, 8};
        vecs[1] = '{11, 16'h059D, 1'b0, 2, 8'hB3, 8, 3, 1, 11};
        vecs[2] = '{8,  16'h006C, 1'b1, 1, 8'h6C, 8, 8, 0, 8};
        vecs[3] = '{5,  16'h0013, 1'b0, 1, 8'h13, 5, 5, 1, 5};
        vecs[4] = '{16, 16'hA55A, 1'b0, 2, 8'hA5, 8, 8, 0, 16};
        vecs[5] = '{3,  16'h0006, 1'b1, 1, 8'h06, 3, 3, 1, 3};
        vecs[6] = '{15, 16'h7FFF, 1'b1, 2, 8'hFF, 8, 7, 1, 15};

        tick(3);
        check_outputs_zero("reset");
        reset = 1'b0;
        enable = 1'b1;
        tick(6);

        $display("[TB] table-driven lines");
        foreach (vecs[v]) begin
            stim_q.delete();
            for (int i = 0; i < vecs[v].n; i++) stim_q.push_back(vecs[v].pattern[vecs[v].n - 1 - i]);
            applyStimulus(vecs[v].coincide);
            checkOutput($sformatf("vec%0d count", v), got_q.size(), vecs[v].exp_words);
            if (got_q.size() > 0) begin
                checkOutput($sformatf("vec%0d first_data", v),
                            int'(got_q[0].d & 8'((1 << vecs[v].exp_first_bits) - 1)),
                            int'(vecs[v].exp_first_data & 8'((1 << vecs[v].exp_first_bits) - 1)));
                idx = got_q.size() - 1;
                checkOutput($sformatf("vec%0d last_bits", v), int'(got_q[idx].b), vecs[v].exp_last_bits);
                checkOutput($sformatf("vec%0d last_flag", v), int'(got_q[idx].l), vecs[v].exp_last_flag);
            end
            if (line_q.size() > 0) checkOutput($sformatf("vec%0d line", v), line_q[0], vecs[v].exp_line);
            verify_line($sformatf("vec%0d", v));
        end

        $display("[TB] randomized lines");
        for (int l = 0; l < 8; l++) begin
            stim_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 40)); i++) stim_q.push_back(1'($urandom));
            applyStimulus(1'($urandom_range(0, 1)));
            verify_line($sformatf("rand%0d", l));
        end

        $display("[TB] overrun with word_ready low");
        stim_q.delete();
        for (int i = 0; i < 16; i++) stim_q.push_back(1'($urandom));
        word_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_bit(stim_q[i], 1'b0);
        tick(6);
        @(negedge clk);
        begin
            logic [7:0] first_word;
            first_word = '0;
            for (int k = 0; k < 8; k++) first_word = {first_word[6:0], stim_q[k]};
            checkOutput("ovr word_valid", int'(word_valid), 1);
            checkOutput("ovr word_data", int'(word_data), int'(first_word));
            checkOutput("ovr word_bits", int'(word_bits), 8);
            checkOutput("ovr word_last", int'(word_last), 0);
            checkOutput("ovr overrun_set", int'(overrun), 1);
            pulse_status_clear();
            checkOutput("ovr overrun_cleared", int'(overrun), 0);
            checkOutput("ovr valid_after_clear", int'(word_valid), 1);
            tick(1);
            word_ready = 1'b1;
            tick(3);
            checkOutput("ovr accepted_count", got_q.size(), 1);
            if (got_q.size() > 0) checkOutput("ovr accepted_data", int'(got_q[0].d), int'(first_word));
        end
        send_latch();
        tick(8);
        checkOutput("ovr line_done_count", line_q.size(), 1);
        if (line_q.size() > 0) checkOutput("ovr line_bits", line_q[0], 16);
        checkOutput("ovr no_partial", got_q.size(), 1);
        got_q.delete();
        line_q.delete();

        $display("[TB] line overflow");
        stim_q.delete();
        for (int i = 0; i < 900; i++) stim_q.push_back(1'($urandom));
        applyStimulus(1'b0);
        verify_line("ovf");
        pulse_status_clear();
        checkOutput("ovf cleared", int'(line_overflow), 0);

        $display("[TB] enable drop mid-line");
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        enable = 1'b0;
        tick(4);
        enable = 1'b1;
        tick(2);
        checkOutput("en no_line_done", line_q.size(), 0);
        stim_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(1'($urandom));
        applyStimulus(1'b0);
        verify_line("en");

        $display("[TB] ph_clk high through reset release");
        begin
            int we_before;
            we_before = we_count;
            ph_clk = 1'b1;
            reset  = 1'b1;
            tick(3);
            reset = 1'b0;
            tick(8);
            checkOutput("rst_hold no_write", we_count - we_before, 0);
            ph_clk = 1'b0;
            tick(3);
        end

        $display("[TB] write latency and reset mid-line");
        word_ready = 1'b0;
        ph_data = 1'b1;
        tick(1);
        ph_clk = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("latency not_yet", int'(sr_write_enable), 0);
        @(negedge clk);
        checkOutput("latency 3_cycles", int'(sr_write_enable), 1);
        @(posedge clk);
        #1 ph_clk = 1'b0;
        tick(3);
        sent_bits++;
        for (int i = 0; i < 9; i++) send_bit(1'($urandom), 1'b0);
        tick(4);
        @(negedge clk);
        checkOutput("midline word_held", int'(word_valid), 1);
        tick(1);
        reset = 1'b1;
        tick(2);
        check_outputs_zero("midline_reset");
        reset = 1'b0;
        word_ready = 1'b1;
        tick(6);
        checkOutput("midline no_line_done", line_q.size(), 0);
        got_q.delete();
        stim_q.delete();
        for (int i = 0; i < 8; i++) stim_q.push_back(1'($urandom));
        applyStimulus(1'b0);
        verify_line("after_reset");

        checkOutput("sr_write_enable single_cycle", double_we, 0);
        checkOutput("sr_write_enable count", we_count, sent_bits);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/printhead_capture_controller.md
PRINTHEAD_CAPTURE_CONTROLLER -- requirements
Module: printhead_capture_controller

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8: bits per captured word; equals the shift register DEPTH.
REQ-002 SHALL have parameter MAX_LINE_BITS, default 832: maximum dots per printhead line; LB_W = clog2(MAX_LINE_BITS+1).
REQ-003 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  capture enable.
REQ-006 SHALL have port ph_clk, ph_data, ph_latch  in  1 each  asynchronous printhead clock, data and latch lines.
REQ-007 SHALL have port sr_write_data, sr_write_enable  out  1 each  drive the SIPO shift register.
REQ-008 SHALL have port sr_read_data  in  WORD_WIDTH  SIPO contents; bit 0 holds the newest bit.
REQ-009 SHALL have port word_data  out  WORD_WIDTH, word_bits  out  clog2(WORD_WIDTH+1), word_last  out  1, word_valid  out  1, word_ready  in  1  captured-word valid/ready stream.
REQ-010 SHALL have port line_done  out  1  one-cycle pulse at end of line; line_bits  out  LB_W  bits in the completed line.
REQ-011 SHALL have port overrun, line_overflow  out  1 each  sticky error flags; status_clear  in  1  clears both.

Function
REQ-012 SHALL pass ph_clk, ph_data and ph_latch through two-flop synchronisers; a third ph_clk/ph_latch stage SHALL provide rising-edge detection.
REQ-013 SHALL ignore detected edges until 3 cycles after reset deasserts (sync pipeline primed).
REQ-014 SHALL implement FSM states DISABLED, CAPTURE, LOAD_WORD, FLUSH; reset state DISABLED.
REQ-015 DISABLED->CAPTURE when enable=1; any state->DISABLED when enable=0, clearing bit counters and pending flush/load; the holding register is retained.
REQ-016 In CAPTURE, on a ph_clk rising edge, SHALL assert sr_write_enable for exactly 1 cycle with sr_write_data = synchronised ph_data; edge at the pin to sr_write_enable high = 3 cycles.
REQ-017 SHALL count bits_in_word (0..WORD_WIDTH) and line_bits (saturating at MAX_LINE_BITS; saturation sets line_overflow).
REQ-018 When bits_in_word reaches WORD_WIDTH, SHALL enter LOAD_WORD next cycle, load word_data = sr_read_data with word_bits = WORD_WIDTH and word_last = 0, reset bits_in_word to 0, and return to CAPTURE.
REQ-019 On a ph_latch rising edge in CAPTURE, SHALL enter FLUSH next cycle.
REQ-020 In FLUSH, if bits_in_word > 0, SHALL load word_data = sr_read_data with word_bits = bits_in_word and word_last = 1; low word_bits bits are valid, upper bits are don't-care.
REQ-021 In FLUSH, SHALL pulse line_done with line_bits = count including all shifted bits; both counters then clear; return to CAPTURE.
REQ-022 If ph_clk and ph_latch edges coincide, SHALL perform the shift first; the bit counts toward the ending line.
REQ-023 If a full word and a latch complete together, SHALL run LOAD_WORD then FLUSH; FLUSH then emits line_done only.
REQ-024 Once loaded, word_valid SHALL stay 1 until a cycle with word_ready=1; word_data, word_bits and word_last SHALL remain stable meanwhile.
REQ-025 If a load occurs while word_valid=1 and word_ready=0, SHALL keep the old word, drop the new one and set overrun.
REQ-026 A load in the same cycle as accept (word_ready=1) SHALL replace the word with word_valid staying 1 and no overrun.
REQ-027 status_clear SHALL clear overrun and line_overflow; a same-cycle set event SHALL take priority.
REQ-028 Input timing requirement: ph_clk high and low times >= 2 clk periods each; violations are out of scope.

Reset
REQ-029 When reset=1 at a clk edge, SHALL clear all state, counters, synchronisers, holding register and flags.
REQ-030 Outputs sr_write_enable, sr_write_data, word_valid, word_last, word_data, word_bits, line_done, line_bits, overrun and line_overflow SHALL reset to 0.
REQ-031 Reset mid-line or mid-word SHALL discard all partial data; no line_done SHALL be issued.

Verification
REQ-032 Scenario: enable=1, 8 ph_clk pulses with data 1,0,1,1,0,0,1,0, word_ready=1 -> 8 single-cycle sr_write_enable, one word with word_bits=8 and word_last=0.
REQ-033 Scenario: 11 bits then ph_latch -> one full word, then partial word with word_bits=3 and word_last=1, line_done with line_bits=11.
REQ-034 Scenario: word_ready=0 across 2 completed words -> first word held stable, overrun=1; status_clear -> overrun=0.
REQ-035 Scenario: same-cycle ph_clk and ph_latch edges after 7 bits -> full word (word_bits=8), line_done with line_bits=8, no partial word.
REQ-036 Scenario: 900 bits then latch -> line_bits=832, line_overflow=1.
REQ-037 Scenario: ph_clk held high through reset release -> no sr_write_enable; reset asserted mid-line -> all outputs 0, no line_done.
